// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx
//  Purpose  : PS/2 keyboard receiver. Synchronises KB_clk/data, deframes
//             11-bit frames (start, 8 data LSB first, odd parity, stop) with
//             a watchdog, decodes E0/F0 prefixes into key events and tracks
//             the E0 6B / E0 74 arrow keys as a paddle direction.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       KB_clk,
  input  logic       data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  output logic [2:0] direction
);

  localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] C_TIMEOUT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] C_WD_ONE  = WD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchroniser stages; PS/2 lines idle high, so reset them high to avoid a
  // spurious fall right after reset release.
  logic kbclk_meta_q, kbclk_sync_q, kbclk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;

  // Frame receiver state
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      code_q, code_d;
  logic            code_valid_q, code_valid_d;
  logic            frame_err_q, frame_err_d;

  // Key-event decoder state
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;
  logic       left_held_q, left_held_d;
  logic       right_held_q, right_held_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_release_q, key_release_d;
  logic       key_valid_q, key_valid_d;
  logic [2:0] direction_q, direction_d;

  // Two-flop synchronisers plus one extra KB_clk stage for fall detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kbclk_meta_q <= 1'b1;
      kbclk_sync_q <= 1'b1;
      kbclk_prev_q <= 1'b1;
      data_meta_q  <= 1'b1;
      data_sync_q  <= 1'b1;
    end else begin
      kbclk_meta_q <= KB_clk;
      kbclk_sync_q <= kbclk_meta_q;
      kbclk_prev_q <= kbclk_sync_q;
      data_meta_q  <= data;
      data_sync_q  <= data_meta_q;
    end
  end

  assign fall = kbclk_prev_q & ~kbclk_sync_q;

  // Frame FSM next-state, shifting, parity/stop checking and watchdog
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if ((state_q == S_IDLE) || fall) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + C_WD_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (fall && !data_sync_q) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d = {data_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = data_sync_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          // Odd parity: data bits plus parity bit must hold an odd count of ones
          if (data_sync_q && (^{shift_q, par_q})) begin
            code_d       = shift_q;
            code_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled partial frame is abandoned; a fall in the same cycle wins
    if ((state_q != S_IDLE) && !fall && (wd_q == C_TIMEOUT)) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      wd_d        = '0;
    end
  end

  // Frame FSM registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      wd_q         <= '0;
      code_q       <= 8'h00;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      wd_q         <= wd_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Prefix decoding, key-event generation and arrow-key hold tracking
  always_comb begin
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    left_held_d   = left_held_q;
    right_held_d  = right_held_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    key_valid_d   = 1'b0;

    if (frame_err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (code_valid_q) begin
      if (code_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (code_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        key_code_d    = code_q;
        key_ext_d     = ext_pend_q;
        key_release_d = brk_pend_q;
        key_valid_d   = 1'b1;
        ext_pend_d    = 1'b0;
        brk_pend_d    = 1'b0;
        if (ext_pend_q && (code_q == 8'h6B)) begin
          left_held_d = ~brk_pend_q;
        end
        if (ext_pend_q && (code_q == 8'h74)) begin
          right_held_d = ~brk_pend_q;
        end
      end
    end

    // Held flags only move on key events, so direction lands with key_valid
    if (left_held_d && !right_held_d) begin
      direction_d = 3'd1;
    end else if (right_held_d && !left_held_d) begin
      direction_d = 3'd2;
    end else begin
      direction_d = 3'd0;
    end
  end

  // Key-event decoder registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      left_held_q   <= 1'b0;
      right_held_q  <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_valid_q   <= 1'b0;
      direction_q   <= 3'd0;
    end else begin
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      left_held_q   <= left_held_d;
      right_held_q  <= right_held_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
      key_valid_q   <= key_valid_d;
      direction_q   <= direction_d;
    end
  end

  assign code        = code_q;
  assign code_valid  = code_valid_q;
  assign frame_err   = frame_err_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;
  assign key_valid   = key_valid_q;
  assign direction   = direction_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_rx
//  Purpose  : Self-checking bench for ps2_rx: directed frame table, timeout
//             and mid-frame reset sequences, then randomized frames against
//             a key-event reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

  localparam int TO = 50000;
  localparam int HP = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       kb_clk = 1'b1;
  logic       kb_data = 1'b1;
  logic [7:0] code, key_code;
  logic       code_valid, frame_err, key_ext, key_release, key_valid;
  logic [2:0] direction;

  ps2_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .KB_clk(kb_clk), .data(kb_data),
    .code(code), .code_valid(code_valid), .frame_err(frame_err),
    .key_code(key_code), .key_ext(key_ext), .key_release(key_release),
    .key_valid(key_valid), .direction(direction)
  );

  always #5 clk = ~clk;

  // Pulse monitor: running totals, last key event, protocol violations
  int         cyc = 0;
  int         cv_total = 0, fe_total = 0, kv_total = 0, viol = 0, fe_cycle = 0;
  logic [7:0] mon_key = 8'h00;
  logic       mon_ext = 1'b0, mon_rel = 1'b0;
  logic [2:0] mon_dir = 3'd0;
  logic       prev_cv = 1'b0, prev_fe = 1'b0, prev_kv = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (code_valid) cv_total <= cv_total + 1;
    if (frame_err) begin
      fe_total <= fe_total + 1;
      fe_cycle <= cyc;
    end
    if (key_valid) begin
      kv_total <= kv_total + 1;
      mon_key  <= key_code;
      mon_ext  <= key_ext;
      mon_rel  <= key_release;
      mon_dir  <= direction;
    end
    if ((code_valid && frame_err) || (code_valid && prev_cv) ||
        (frame_err && prev_fe) || (key_valid && prev_kv))
      viol <= viol + 1;
    prev_cv <= code_valid;
    prev_fe <= frame_err;
    prev_kv <= key_valid;
  end

  int n_pass = 0, n_checks = 0;
  int last_fall_cyc = 0;
  int b_cv, b_fe, b_kv;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic snap();
    b_cv = cv_total;
    b_fe = fe_total;
    b_kv = kv_total;
  endtask

  task automatic drive_bit(input logic b, input int hp);
    @(negedge clk);
    kb_data = b;
    repeat (hp) @(negedge clk);
    kb_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (hp) @(negedge clk);
    kb_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int hp);
    drive_bit(1'b0, hp);
    for (int i = 0; i < 8; i++) drive_bit(b[i], hp);
    drive_bit(par, hp);
    drive_bit(stop, hp);
    @(negedge clk);
    kb_data = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Checks the pulses produced by one frame plus the resulting output state
  task automatic chk_frame(input int e_cv, input int e_fe, input int e_kv,
                           input logic [7:0] e_key, input logic e_ext, input logic e_rel,
                           input logic [2:0] e_dir, input logic [7:0] e_code);
    chk("code_valid_count", cv_total - b_cv, e_cv);
    chk("frame_err_count", fe_total - b_fe, e_fe);
    chk("key_valid_count", kv_total - b_kv, e_kv);
    chk("code", code, e_code);
    chk("direction", direction, e_dir);
    if (e_kv == 1) begin
      chk("key_code", mon_key, e_key);
      chk("key_ext", mon_ext, e_ext);
      chk("key_release", mon_rel, e_rel);
      chk("direction_at_key_valid", mon_dir, e_dir);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    int         e_cv;
    int         e_fe;
    int         e_kv;
    logic       e_ext;
    logic       e_rel;
    logic [2:0] e_dir;
    logic [7:0] e_code;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] b, logic bp, logic bs, int cv, int fe, int kv,
                              logic ex, logic rl, logic [2:0] dr, logic [7:0] cd);
    vec_t v;
    v.b = b; v.bad_par = bp; v.bad_stop = bs; v.e_cv = cv; v.e_fe = fe; v.e_kv = kv;
    v.e_ext = ex; v.e_rel = rl; v.e_dir = dr; v.e_code = cd;
    return v;
  endfunction

  function automatic logic [2:0] dir_of(logic l, logic r);
    if (l && !r) return 3'd1;
    if (r && !l) return 3'd2;
    return 3'd0;
  endfunction

  initial begin
    logic [7:0] rb;
    logic       bp, bs, good;
    logic       m_ext, m_brk, m_left, m_right;
    logic [7:0] m_code, e_key;
    logic       e_ext, e_rel;
    int         e_kv, rhp, t0, delta;

    // Reset values
    repeat (4) @(negedge clk);
    chk("rst_code", code, 8'h00);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_direction", direction, 3'd0);
    chk("rst_strobes", {code_valid, frame_err, key_valid, key_ext, key_release}, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Directed frame table:   byte bp bs cv fe kv ext rel dir code
    tbl.push_back(mk(8'h1C, 0, 0, 1, 0, 1, 0, 0, 3'd0, 8'h1C));
    tbl.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'hE0));
    tbl.push_back(mk(8'h6B, 0, 0, 1, 0, 1, 1, 0, 3'd1, 8'h6B));
    tbl.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0, 0, 3'd1, 8'hE0));
    tbl.push_back(mk(8'hF0, 0, 0, 1, 0, 0, 0, 0, 3'd1, 8'hF0));
    tbl.push_back(mk(8'h6B, 0, 0, 1, 0, 1, 1, 1, 3'd0, 8'h6B));
    tbl.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'hE0));
    tbl.push_back(mk(8'h6B, 0, 0, 1, 0, 1, 1, 0, 3'd1, 8'h6B));
    tbl.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0, 0, 3'd1, 8'hE0));
    tbl.push_back(mk(8'h74, 0, 0, 1, 0, 1, 1, 0, 3'd0, 8'h74));
    tbl.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'hE0));
    tbl.push_back(mk(8'hF0, 0, 0, 1, 0, 0, 0, 0, 3'd0, 8'hF0));
    tbl.push_back(mk(8'h6B, 0, 0, 1, 0, 1, 1, 1, 3'd2, 8'h6B));
    tbl.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0, 0, 3'd2, 8'hE0));
    tbl.push_back(mk(8'h1C, 1, 0, 0, 1, 0, 0, 0, 3'd2, 8'hE0));
    tbl.push_back(mk(8'hF0, 0, 0, 1, 0, 0, 0, 0, 3'd2, 8'hF0));
    tbl.push_back(mk(8'h1C, 0, 0, 1, 0, 1, 0, 1, 3'd2, 8'h1C));
    tbl.push_back(mk(8'hE0, 0, 0, 1, 0, 0, 0, 0, 3'd2, 8'hE0));
    tbl.push_back(mk(8'hF0, 0, 0, 1, 0, 0, 0, 0, 3'd2, 8'hF0));
    tbl.push_back(mk(8'h74, 0, 0, 1, 0, 1, 1, 1, 3'd0, 8'h74));
    tbl.push_back(mk(8'h29, 0, 1, 0, 1, 0, 0, 0, 3'd0, 8'h74));
    tbl.push_back(mk(8'h29, 0, 0, 1, 0, 1, 0, 0, 3'd0, 8'h29));

    foreach (tbl[i]) begin
      snap();
      send_frame(tbl[i].b, (~^tbl[i].b) ^ tbl[i].bad_par, ~tbl[i].bad_stop, HP);
      chk_frame(tbl[i].e_cv, tbl[i].e_fe, tbl[i].e_kv, tbl[i].b, tbl[i].e_ext,
                tbl[i].e_rel, tbl[i].e_dir, tbl[i].e_code);
    end

    // Stalled frame: start + 4 data bits, then silence past the watchdog
    snap();
    drive_bit(1'b0, HP);
    for (int i = 0; i < 4; i++) drive_bit(i[0], HP);
    t0 = last_fall_cyc;
    repeat (60000) @(negedge clk);
    delta = fe_cycle - t0;
    chk("timeout_frame_err_count", fe_total - b_fe, 1);
    chk("timeout_code_valid_count", cv_total - b_cv, 0);
    chk("timeout_latency_in_window", int'((delta >= TO) && (delta <= TO + 8)), 1);
    snap();
    send_frame(8'h29, ~^8'h29, 1'b1, HP);
    chk_frame(1, 0, 1, 8'h29, 1'b0, 1'b0, 3'd0, 8'h29);

    // Reset asserted mid-frame, then a clean frame
    snap();
    drive_bit(1'b0, HP);
    drive_bit(1'b0, HP);
    drive_bit(1'b0, HP);
    drive_bit(1'b1, HP);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_code", code, 8'h00);
    chk("midrst_key_code", key_code, 8'h00);
    chk("midrst_direction", direction, 3'd0);
    chk("midrst_strobes", {code_valid, frame_err, key_valid, key_ext, key_release}, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    snap();
    send_frame(8'h74, ~^8'h74, 1'b1, HP);
    chk_frame(1, 0, 1, 8'h74, 1'b0, 1'b0, 3'd0, 8'h74);

    // Randomized frames against the key-event model
    m_ext = 1'b0; m_brk = 1'b0; m_left = 1'b0; m_right = 1'b0; m_code = 8'h74;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    rb = 8'hE0;
        2:       rb = 8'hF0;
        3:       rb = 8'h6B;
        4:       rb = 8'h74;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      bp   = ($urandom_range(0, 7) == 0);
      bs   = ($urandom_range(0, 15) == 0);
      rhp  = $urandom_range(4, 10);
      good = !bp && !bs;
      e_kv = 0; e_key = 8'h00; e_ext = 1'b0; e_rel = 1'b0;
      if (good) begin
        m_code = rb;
        if (rb == 8'hE0) m_ext = 1'b1;
        else if (rb == 8'hF0) m_brk = 1'b1;
        else begin
          e_kv = 1; e_key = rb; e_ext = m_ext; e_rel = m_brk;
          if (m_ext && rb == 8'h6B) m_left = !m_brk;
          if (m_ext && rb == 8'h74) m_right = !m_brk;
          m_ext = 1'b0; m_brk = 1'b0;
        end
      end else begin
        m_ext = 1'b0; m_brk = 1'b0;
      end
      snap();
      send_frame(rb, (~^rb) ^ bp, ~bs, rhp);
      chk_frame(int'(good), int'(!good), e_kv, e_key, e_ext, e_rel,
                dir_of(m_left, m_right), m_code);
    end

    chk("pulse_protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
